// File: rtl/ir_transmit_sm.sv
// IR car-control packet generator.
// Emits the start, car-select, gap and direction bursts of one packet per request.
module ir_transmit_sm #(
  parameter int CARRIER_HALF  = 1389,
  parameter int START_SIZE    = 191,
  parameter int CARSEL_SIZE   = 47,
  parameter int GAP_SIZE      = 25,
  parameter int ASSERT_SIZE   = 47,
  parameter int DEASSERT_SIZE = 22
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] COMMAND,
  input  logic       SEND_PACKET,
  output logic       IR_LED,
  output logic       BUSY,
  output logic       PACKET_DONE
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXS = max2(max2(START_SIZE, CARSEL_SIZE),
                             max2(GAP_SIZE,
                                  max2(ASSERT_SIZE, DEASSERT_SIZE)));
  localparam int PW = $clog2(MAXS + 1);
  localparam int HW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_GAP0   = 4'd2;
  localparam logic [3:0] S_CARSEL = 4'd3;
  localparam logic [3:0] S_GAP1   = 4'd4;
  localparam logic [3:0] S_RIGHT  = 4'd5;
  localparam logic [3:0] S_GAP2   = 4'd6;
  localparam logic [3:0] S_LEFT   = 4'd7;
  localparam logic [3:0] S_GAP3   = 4'd8;
  localparam logic [3:0] S_BACK   = 4'd9;
  localparam logic [3:0] S_GAP4   = 4'd10;
  localparam logic [3:0] S_FWD    = 4'd11;

  localparam logic [PW-1:0] SZ_START  = PW'(START_SIZE);
  localparam logic [PW-1:0] SZ_CARSEL = PW'(CARSEL_SIZE);
  localparam logic [PW-1:0] SZ_GAP    = PW'(GAP_SIZE);
  localparam logic [PW-1:0] SZ_ASRT   = PW'(ASSERT_SIZE);
  localparam logic [PW-1:0] SZ_DEASRT = PW'(DEASSERT_SIZE);
  localparam logic [HW-1:0] HALF_LAST = HW'(CARRIER_HALF - 1);

  logic [3:0]    r_state;
  logic [3:0]    r_cmd;
  logic [HW-1:0] r_half;
  logic [PW-1:0] r_per;
  logic          r_phase;
  logic          r_led;
  logic          r_busy;
  logic          r_done;

  logic [PW-1:0] w_size;
  logic [PW-1:0] w_per_inc;
  logic          w_half_end;
  logic          w_per_end;
  logic          w_last;
  logic          w_nxt_phase;
  logic          w_accept;

  always_comb begin
    w_size = SZ_GAP;
    case (r_state)
      S_START:  w_size = SZ_START;
      S_CARSEL: w_size = SZ_CARSEL;
      S_RIGHT:  w_size = r_cmd[0] ? SZ_ASRT : SZ_DEASRT;
      S_LEFT:   w_size = r_cmd[1] ? SZ_ASRT : SZ_DEASRT;
      S_BACK:   w_size = r_cmd[2] ? SZ_ASRT : SZ_DEASRT;
      S_FWD:    w_size = r_cmd[3] ? SZ_ASRT : SZ_DEASRT;
      default:  w_size = SZ_GAP;
    endcase
  end

  // A period ends on the last cycle of the low phase.
  assign w_half_end  = (r_half == HALF_LAST);
  assign w_per_end   = w_half_end && !r_phase;
  assign w_per_inc   = r_per + PW'(1);
  assign w_last      = w_per_end && (w_per_inc == w_size);
  assign w_nxt_phase = w_half_end ? !r_phase : r_phase;
  assign w_accept    = SEND_PACKET && !r_done;

  // Odd states are bursts, even non-idle states are gaps.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_half  <= '0;
      r_per   <= '0;
      r_phase <= 1'b0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_done <= 1'b0;
      r_half <= '0;
      r_per  <= '0;
      if (w_accept) begin
        r_cmd   <= COMMAND;
        r_state <= S_START;
        r_phase <= 1'b1;
        r_led   <= 1'b1;
        r_busy  <= 1'b1;
      end else begin
        r_phase <= 1'b0;
        r_led   <= 1'b0;
        r_busy  <= 1'b0;
      end
    end else if (w_last) begin
      r_half  <= '0;
      r_per   <= '0;
      r_phase <= 1'b1;
      if (r_state == S_FWD) begin
        r_state <= S_IDLE;
        r_led   <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        r_state <= r_state + 4'd1;
        r_led   <= !r_state[0];
      end
    end else begin
      r_done  <= 1'b0;
      r_phase <= w_nxt_phase;
      r_led   <= r_state[0] && w_nxt_phase;
      if (w_half_end) begin
        r_half <= '0;
        if (w_per_end) r_per <= w_per_inc;
      end else begin
        r_half <= r_half + HW'(1);
      end
    end
  end

  assign IR_LED      = r_led;
  assign BUSY        = r_busy;
  assign PACKET_DONE = r_done;

endmodule

// File: tb/tb_ir_transmit_sm.sv
// Directed bench for ir_transmit_sm.
// Small parameters; waveform checked against a burst-list model.
module tb_ir_transmit_sm;

  localparam int CH = 2;
  localparam int SS = 3;
  localparam int CS = 2;
  localparam int GS = 1;
  localparam int AS = 2;
  localparam int DS = 1;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [3:0] COMMAND = 4'h0;
  logic       SEND_PACKET = 1'b0;
  logic       IR_LED;
  logic       BUSY;
  logic       PACKET_DONE;

  int n_vec = 0;
  int n_bad = 0;

  bit exp_led [0:255];
  int exp_n;

  typedef struct {
    logic [3:0] cmd;
    logic [3:0] cmd_after;
    bit         extra;
    int         len;
  } vec_t;

  vec_t vecs [6];

  ir_transmit_sm #(
    .CARRIER_HALF(CH), .START_SIZE(SS), .CARSEL_SIZE(CS),
    .GAP_SIZE(GS), .ASSERT_SIZE(AS), .DEASSERT_SIZE(DS)
  ) dut (
    .CLK(CLK), .RESET(RESET), .COMMAND(COMMAND),
    .SEND_PACKET(SEND_PACKET), .IR_LED(IR_LED),
    .BUSY(BUSY), .PACKET_DONE(PACKET_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic add_seg(input bit burst, input int periods);
    for (int p = 0; p < periods; p++)
      for (int k = 0; k < 2*CH; k++) begin
        exp_led[exp_n] = burst && (k < CH);
        exp_n++;
      end
  endtask

  task automatic build_exp(input logic [3:0] c);
    exp_n = 0;
    add_seg(1, SS);
    add_seg(0, GS);
    add_seg(1, CS);
    for (int d = 0; d < 4; d++) begin
      add_seg(0, GS);
      add_seg(1, c[d] ? AS : DS);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int busy_n, mis, done_n, fall_ok;
    logic prev_busy;
    build_exp(v.cmd);
    @(negedge CLK);
    COMMAND = v.cmd;
    SEND_PACKET = 1'b1;
    @(negedge CLK);
    SEND_PACKET = 1'b0;
    COMMAND = v.cmd_after;
    busy_n = 0; mis = 0; done_n = 0; fall_ok = 0;
    prev_busy = 1'b1;
    for (int cyc = 0; cyc < 150; cyc++) begin
      if (BUSY) begin
        if (busy_n < exp_n) begin
          if (IR_LED !== exp_led[busy_n]) mis++;
        end else if (IR_LED !== 1'b0) mis++;
        busy_n++;
      end else if (IR_LED !== 1'b0) mis++;
      if (PACKET_DONE) begin
        done_n++;
        if (!BUSY && prev_busy && busy_n == v.len) fall_ok = 1;
        if (v.extra) SEND_PACKET = 1'b1;
      end
      if (v.extra && (cyc == 10 || cyc == 30)) SEND_PACKET = 1'b1;
      prev_busy = BUSY;
      @(negedge CLK);
      SEND_PACKET = 1'b0;
    end
    check($sformatf("v%0d busy_len", idx), busy_n, v.len);
    check($sformatf("v%0d model_len", idx), exp_n, v.len);
    check($sformatf("v%0d led_mismatch_cycles", idx), mis, 0);
    check($sformatf("v%0d done_pulses", idx), done_n, 1);
    check($sformatf("v%0d done_at_busy_fall", idx), fall_ok, 1);
  endtask

  initial begin
    int bad;
    vecs[0] = '{cmd: 4'h0, cmd_after: 4'h0, extra: 0, len: 56};
    vecs[1] = '{cmd: 4'hF, cmd_after: 4'hF, extra: 0, len: 72};
    vecs[2] = '{cmd: 4'hA, cmd_after: 4'h5, extra: 0, len: 64};
    vecs[3] = '{cmd: 4'h0, cmd_after: 4'h0, extra: 1, len: 56};
    vecs[4] = '{cmd: 4'h3, cmd_after: 4'hC, extra: 0, len: 64};
    vecs[5] = '{cmd: 4'h1, cmd_after: 4'h1, extra: 0, len: 60};

    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (IR_LED !== 1'b0 || BUSY !== 1'b0 || PACKET_DONE !== 1'b0) bad++;
    end
    check("in_reset_outputs_nonzero", bad, 0);
    RESET = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (IR_LED !== 1'b0 || BUSY !== 1'b0 || PACKET_DONE !== 1'b0) bad++;
    end
    check("idle_outputs_nonzero", bad, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    @(negedge CLK);
    COMMAND = 4'h0;
    SEND_PACKET = 1'b1;
    @(negedge CLK);
    SEND_PACKET = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (PACKET_DONE !== 1'b0) bad++;
      @(negedge CLK);
    end
    check("carsel_led_before_reset", int'(IR_LED), 1);
    check("carsel_busy_before_reset", int'(BUSY), 1);
    #2 RESET = 1'b0;
    #1;
    check("async_reset_led", int'(IR_LED), 0);
    check("async_reset_busy", int'(BUSY), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (PACKET_DONE !== 1'b0) bad++;
    end
    RESET = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (PACKET_DONE !== 1'b0 || BUSY !== 1'b0 || IR_LED !== 1'b0) bad++;
    end
    check("no_resume_after_reset", bad, 0);
    run_vec(vecs[0], 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
